// File: rtl/wb_port_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : wb_port_arbiter_if
// Brief    : Request ports A/B and the registered register-file write port.
// Revision : 1.0
// ============================================================================
interface wb_port_arbiter_if #(
    parameter int DATA_W = 32
);
    logic              a_req;
    logic [4:0]        a_addr;
    logic [DATA_W-1:0] a_data;
    logic              a_ready;
    logic              b_req;
    logic [4:0]        b_addr;
    logic [DATA_W-1:0] b_data;
    logic              b_ready;
    logic              wb_we;
    logic [4:0]        wb_addr;
    logic [DATA_W-1:0] wb_data;
    logic              wb_src;

    // Arbiter side
    modport slave (
        input  a_req, a_addr, a_data, b_req, b_addr, b_data,
        output a_ready, b_ready, wb_we, wb_addr, wb_data, wb_src
    );

    // Requester / register-file side
    modport master (
        output a_req, a_addr, a_data, b_req, b_addr, b_data,
        input  a_ready, b_ready, wb_we, wb_addr, wb_data, wb_src
    );
endinterface
`default_nettype wire

// File: rtl/wb_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : wb_port_arbiter
// Brief    : Two-source arbiter for the register file write port. Define
//            WB_ARB_STARVE_EN for starvation-protected priority (else A wins).
// Revision : 1.0
// ============================================================================
module wb_port_arbiter #(
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  wire logic          clk,
    input  wire logic          rst,
    wb_port_arbiter_if.slave   bus
);

    if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15) begin : g_bad_limit
        $error("wb_port_arbiter: STARVE_LIMIT must be in 1..15");
    end

    logic              w_grant_a;
    logic              w_grant_b;
    logic              w_grant;
    logic [4:0]        w_sel_addr;
    logic [DATA_W-1:0] w_sel_data;

    logic              r_wb_we;
    logic [4:0]        r_wb_addr;
    logic [DATA_W-1:0] r_wb_data;
    logic              r_wb_src;

`ifdef WB_ARB_STARVE_EN
    typedef enum logic [0:0] {
        PRI_A = 1'b0,
        PRI_B = 1'b1
    } state_t;

    localparam logic [3:0] c_LIMIT = 4'(STARVE_LIMIT);

    state_t     r_state;
    logic [3:0] r_starve_cnt;
    logic [3:0] w_starve_nxt;

    always_comb begin
        w_grant_a = !rst && bus.a_req && ((r_state == PRI_A) || !bus.b_req);
        w_grant_b = !rst && bus.b_req && ((r_state == PRI_B) || !bus.a_req);

        // Counts consecutive refused B cycles; saturates at the limit.
        w_starve_nxt = r_starve_cnt;
        if (!bus.b_req || w_grant_b) begin
            w_starve_nxt = 4'd0;
        end else if (r_starve_cnt < c_LIMIT) begin
            w_starve_nxt = r_starve_cnt + 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= PRI_A;
            r_starve_cnt <= 4'd0;
        end else begin
            r_starve_cnt <= w_starve_nxt;
            case (r_state)
                PRI_A: if (w_starve_nxt == c_LIMIT)     r_state <= PRI_B;
                PRI_B: if (w_grant_b || !bus.b_req)     r_state <= PRI_A;
                default:                                r_state <= PRI_A;
            endcase
        end
    end
`else
    always_comb begin
        w_grant_a = !rst && bus.a_req;
        w_grant_b = !rst && bus.b_req && !bus.a_req;
    end
`endif

    always_comb begin
        w_grant    = w_grant_a || w_grant_b;
        w_sel_addr = w_grant_b ? bus.b_addr : bus.a_addr;
        w_sel_data = w_grant_b ? bus.b_data : bus.a_data;
    end

    // Writes to $0 complete the handshake but never raise the enable.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wb_we   <= 1'b0;
            r_wb_addr <= 5'd0;
            r_wb_data <= '0;
            r_wb_src  <= 1'b0;
        end else begin
            r_wb_we <= w_grant && (w_sel_addr != 5'd0);
            if (w_grant) begin
                r_wb_addr <= w_sel_addr;
                r_wb_data <= w_sel_data;
                r_wb_src  <= w_grant_b;
            end
        end
    end

    assign bus.a_ready = w_grant_a;
    assign bus.b_ready = w_grant_b;
    assign bus.wb_we   = r_wb_we;
    assign bus.wb_addr = r_wb_addr;
    assign bus.wb_data = r_wb_data;
    assign bus.wb_src  = r_wb_src;

endmodule
`default_nettype wire

// File: tb/tb_wb_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_wb_port_arbiter
// Brief    : Directed scoreboard bench for wb_port_arbiter.
// Revision : 1.0
// ============================================================================
module tb_wb_port_arbiter;

    logic clk;
    logic rst;

    wb_port_arbiter_if #(.DATA_W(32)) bus ();

    wb_port_arbiter #(
        .DATA_W       (32),
        .STARVE_LIMIT (4)
    ) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        ar;
        logic        br;
        logic        we;
        logic [4:0]  addr;
        logic [31:0] data;
        logic        src;
    } exp_t;

    exp_t q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    bit   done    = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    // Readies are checked in the cycle the vector is applied; write-port
    // expectations are checked one edge later.
    initial begin : monitor
        exp_t pend;
        bit   have_pend;
        have_pend = 0;
        forever begin
            @(negedge clk);
            if (have_pend) begin
                chk("wb_we",   32'(bus.wb_we),   32'(pend.we));
                chk("wb_addr", 32'(bus.wb_addr), 32'(pend.addr));
                chk("wb_data", bus.wb_data,      pend.data);
                chk("wb_src",  32'(bus.wb_src),  32'(pend.src));
                have_pend = 0;
            end
            if (q.size() != 0) begin
                pend = q.pop_front();
                chk("a_ready", 32'(bus.a_ready), 32'(pend.ar));
                chk("b_ready", 32'(bus.b_ready), 32'(pend.br));
                have_pend = 1;
            end
        end
    end

    task automatic drv(input logic r,
                       input logic ar_q, input logic [4:0] aa, input logic [31:0] ad,
                       input logic br_q, input logic [4:0] ba, input logic [31:0] bd,
                       input logic e_ar, input logic e_br, input logic e_we,
                       input logic [4:0] e_addr, input logic [31:0] e_data, input logic e_src);
        exp_t e;
        @(posedge clk);
        #2;
        rst        = r;
        bus.a_req  = ar_q;
        bus.a_addr = aa;
        bus.a_data = ad;
        bus.b_req  = br_q;
        bus.b_addr = ba;
        bus.b_data = bd;
        e.ar = e_ar; e.br = e_br; e.we = e_we;
        e.addr = e_addr; e.data = e_data; e.src = e_src;
        q.push_back(e);
    endtask

    initial begin : stim
        rst = 1'b1;
        bus.a_req = 1'b1; bus.a_addr = 5'd8; bus.a_data = 32'hDEADBEEF;
        bus.b_req = 1'b1; bus.b_addr = 5'd3; bus.b_data = 32'h0000B0B0;

        // Reset with both ports requesting
        drv(1, 1, 5'd8, 32'hDEADBEEF, 1, 5'd3, 32'hB0B0, 0, 0, 0, 5'd0, 32'h0, 0);
        drv(1, 1, 5'd8, 32'hDEADBEEF, 1, 5'd3, 32'hB0B0, 0, 0, 0, 5'd0, 32'h0, 0);
        drv(0, 0, 5'd0, 32'h0,        0, 5'd0, 32'h0,    0, 0, 0, 5'd0, 32'h0, 0);
        // Single A write, then idle hold
        drv(0, 1, 5'd8, 32'hDEADBEEF, 0, 5'd0, 32'h0,    1, 0, 1, 5'd8, 32'hDEADBEEF, 0);
        drv(0, 0, 5'd0, 32'h0,        0, 5'd0, 32'h0,    0, 0, 0, 5'd8, 32'hDEADBEEF, 0);
        // $0 destination
        drv(0, 1, 5'd0, 32'h1234,     0, 5'd0, 32'h0,    1, 0, 0, 5'd0, 32'h1234, 0);
        // Lone B write, then idle hold
        drv(0, 0, 5'd0, 32'h0,        1, 5'd5, 32'h55,   0, 1, 1, 5'd5, 32'h55, 1);
        drv(0, 0, 5'd0, 32'h0,        0, 5'd0, 32'h0,    0, 0, 0, 5'd5, 32'h55, 1);

        // Collision: A every cycle, B held at $3
        drv(0, 1, 5'd10, 32'hA0, 1, 5'd3, 32'hB3, 1, 0, 1, 5'd10, 32'hA0, 0);
        drv(0, 1, 5'd11, 32'hA1, 1, 5'd3, 32'hB3, 1, 0, 1, 5'd11, 32'hA1, 0);
        drv(0, 1, 5'd12, 32'hA2, 1, 5'd3, 32'hB3, 1, 0, 1, 5'd12, 32'hA2, 0);
        drv(0, 1, 5'd13, 32'hA3, 1, 5'd3, 32'hB3, 1, 0, 1, 5'd13, 32'hA3, 0);
`ifdef WB_ARB_STARVE_EN
        drv(0, 1, 5'd14, 32'hA4, 1, 5'd3, 32'hB3, 0, 1, 1, 5'd3,  32'hB3, 1);
        drv(0, 1, 5'd14, 32'hA4, 0, 5'd0, 32'h0,  1, 0, 1, 5'd14, 32'hA4, 0);
        drv(0, 0, 5'd0,  32'h0,  0, 5'd0, 32'h0,  0, 0, 0, 5'd14, 32'hA4, 0);
`else
        drv(0, 1, 5'd14, 32'hA4, 1, 5'd3, 32'hB3, 1, 0, 1, 5'd14, 32'hA4, 0);
        drv(0, 1, 5'd15, 32'hA5, 1, 5'd3, 32'hB3, 1, 0, 1, 5'd15, 32'hA5, 0);
        drv(0, 0, 5'd0,  32'h0,  1, 5'd3, 32'hB3, 0, 1, 1, 5'd3,  32'hB3, 1);
        drv(0, 0, 5'd0,  32'h0,  0, 5'd0, 32'h0,  0, 0, 0, 5'd3,  32'hB3, 1);
`endif

        // Starve B up to the limit, then reset with both still requesting
        drv(0, 1, 5'd20, 32'h20, 1, 5'd7, 32'h77, 1, 0, 1, 5'd20, 32'h20, 0);
        drv(0, 1, 5'd21, 32'h21, 1, 5'd7, 32'h77, 1, 0, 1, 5'd21, 32'h21, 0);
        drv(0, 1, 5'd22, 32'h22, 1, 5'd7, 32'h77, 1, 0, 1, 5'd22, 32'h22, 0);
        drv(0, 1, 5'd23, 32'h23, 1, 5'd7, 32'h77, 1, 0, 1, 5'd23, 32'h23, 0);
        drv(1, 1, 5'd24, 32'h24, 1, 5'd7, 32'h77, 0, 0, 0, 5'd0,  32'h0,  0);
        // After release A wins and B needs a fresh run of refusals
        drv(0, 1, 5'd24, 32'h24, 1, 5'd7, 32'h77, 1, 0, 1, 5'd24, 32'h24, 0);
        drv(0, 1, 5'd25, 32'h25, 1, 5'd7, 32'h77, 1, 0, 1, 5'd25, 32'h25, 0);
        drv(0, 1, 5'd26, 32'h26, 1, 5'd7, 32'h77, 1, 0, 1, 5'd26, 32'h26, 0);
        drv(0, 1, 5'd27, 32'h27, 1, 5'd7, 32'h77, 1, 0, 1, 5'd27, 32'h27, 0);
`ifdef WB_ARB_STARVE_EN
        drv(0, 1, 5'd28, 32'h28, 1, 5'd7, 32'h77, 0, 1, 1, 5'd7,  32'h77, 1);
        drv(0, 0, 5'd0,  32'h0,  0, 5'd0, 32'h0,  0, 0, 0, 5'd7,  32'h77, 1);
`else
        drv(0, 1, 5'd28, 32'h28, 1, 5'd7, 32'h77, 1, 0, 1, 5'd28, 32'h28, 0);
        drv(0, 0, 5'd0,  32'h0,  0, 5'd0, 32'h0,  0, 0, 0, 5'd28, 32'h28, 0);
`endif

        repeat (4) @(negedge clk);
        n_tests++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expectations left, expected 0", q.size());
        end
        done = 1;
    end

    initial begin : finisher
        fork
            wait (done);
            begin
                #100000;
                n_tests++;
                n_fail++;
                $display("FAIL timeout: bench did not finish, expected completion");
            end
        join_any
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/wb_port_arbiter.md
# wb_port_arbiter

Shares the register file's single write port between two writeback sources: the main pipeline writeback stage (port A) and the multi-cycle unit (MDU/load return, port B). Each cycle it grants at most one requester and registers the selected 5-bit destination, 32-bit data and source select. The registered select (`wb_src`) drives the destination/data select muxes at the register-file input. A starvation counter guarantees port B forward progress under continuous port A traffic.

## Interface
Parameters:
- `DATA_W`, 32, writeback data width
- `STARVE_LIMIT`, 4, consecutive cycles B may be refused before forced priority (1..15)

Ports:
- `clk`  in  1  clock, rising edge
- `rst`  in  1  synchronous, active-high reset
- `a_req`  in  1  port A write request
- `a_addr`  in  5  port A destination register
- `a_data`  in  DATA_W  port A write data
- `a_ready`  out  1  port A accepted this cycle (combinational)
- `b_req`  in  1  port B write request
- `b_addr`  in  5  port B destination register
- `b_data`  in  DATA_W  port B write data
- `b_ready`  out  1  port B accepted this cycle (combinational)
- `wb_we`  out  1  register-file write enable (registered)
- `wb_addr`  out  5  register-file write address (registered)
- `wb_data`  out  DATA_W  register-file write data (registered)
- `wb_src`  out  1  0 = A, 1 = B; select for downstream muxes (registered)

## Operation
- Handshake: transfer on `x_req && x_ready`. Requester holds `req`, `addr` and `data` stable until accepted.
- States: `PRI_A` (reset) and `PRI_B`.
- `PRI_A`: grant A if `a_req`, otherwise grant B if `b_req`.
- `PRI_B`: grant B if `b_req`, otherwise A.
- `starve_cnt` (4 bits):
  - Increments each cycle `b_req && !b_ready`.
  - Clears on a B grant or when `b_req` is low.
  - Saturates at `STARVE_LIMIT`.
- Transitions:
  - `PRI_A` to `PRI_B` when the next `starve_cnt` value equals `STARVE_LIMIT`.
  - `PRI_B` to `PRI_A` after a B grant, or when `b_req` is low.
- `a_ready` and `b_ready` are never both 1. Both are 0 while `rst` is high.
- Destination `$0`: the handshake completes normally, but `wb_we` stays 0 and `wb_addr`/`wb_data` still update.
- Both ports requesting the same address: requests are not merged. The two writes occur in grant order.

## Timing
- Grant decision is combinational from `req` and state. Outputs register on the edge where the transfer occurs.
- Latency: write visible at the register file one cycle after acceptance.
- Throughput: one write per cycle. The refused port waits with no bubble inserted.
- Reset values: `wb_we=0`, `wb_addr=0`, `wb_data=0`, `wb_src=0`, state `PRI_A`, `starve_cnt=0`.
- Reset mid-operation: pending requests are dropped with no acceptance. Outputs take reset values on the next edge.
- No request: `wb_we=0` next cycle. `wb_addr`, `wb_data` and `wb_src` hold their last value.

## Configuration
- `WB_ARB_STARVE_EN` defined: starvation counter and `PRI_B` state present, as described above.
- Not defined: fixed priority.
  - A always wins.
  - B is granted only when `a_req` is low.
  - `STARVE_LIMIT` is ignored and no counter is synthesized.

## Test plan
- Reset: assert `rst` with `a_req=b_req=1` -> `a_ready=b_ready=0`. Next cycle `wb_we=0`, `wb_addr=0`, `wb_data=0`, `wb_src=0`.
- Single A write, `a_addr=5'd8`, `a_data=32'hDEADBEEF` -> `a_ready=1` same cycle. Next cycle `wb_we=1`, `wb_addr=8`, `wb_data=DEADBEEF`, `wb_src=0`.
- Collision, `STARVE_LIMIT=4`, A requesting every cycle, B held with `b_addr=3`:
  - A granted 4 cycles, then `b_ready=1` on the 5th.
  - Following cycle `wb_src=1`, `wb_addr=3`.
  - A resumes the cycle after.
- Same case without `WB_ARB_STARVE_EN` -> `b_ready` stays 0 until `a_req` drops. First idle-A cycle grants B.
- `$0` write: `a_addr=0`, `a_data=32'h1234` -> `a_ready=1`. Next cycle `wb_we=0`, `wb_addr=0`, `wb_data=1234`.
- Reset while state is `PRI_B` with `starve_cnt` saturated -> after release, A wins a simultaneous request and the counter restarts from 0.
